multi_tick_generator: RTL and testbench

//   N_CH independent tick generators (strobe sources) sharing one clock.

---
 rtl/multi_tick_generator.sv | 127 ++++++++++++
 tb/tb_multi_tick_generator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_generator.sv
// N_CH independent programmable tick (strobe) generators with periodic/one-shot modes and a
// valid/ready config port whose updates are applied only at period boundaries or while idle.
module multi_tick_generator #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 1000,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic              cfg_err,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   done
);

  logic              w_ch_valid;
  logic              w_accept;
  logic [WIDTH-1:0]  w_cfg_div;
  logic [N_CH-1:0]   w_pending;
  logic              r_cfg_err;

  assign w_ch_valid = (32'(cfg_ch) < N_CH);
  assign w_cfg_div  = (cfg_div == '0) ? WIDTH'(1) : cfg_div;

  // Out-of-range requests are always accepted so the requester never stalls on a bad index.
  always_comb begin
    cfg_ready = 1'b1;
    if (w_ch_valid) begin
      cfg_ready = ~w_pending[cfg_ch];
    end
  end

  assign w_accept = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_valid & ~w_ch_valid;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_sh_div;
    logic             r_oneshot;
    logic             r_sh_oneshot;
    logic             r_pending;
    logic             r_tick;
    logic             r_done;
    logic             w_active;
    logic             w_roll;
    logic             w_commit;
    logic             w_load;

    assign w_active = en & ch_en[i] & ~r_done;
    assign w_roll   = w_active & (r_count == (r_div - WIDTH'(1)));
    assign w_commit = r_pending & (sync | ~w_active | w_roll);
    assign w_load   = w_accept & w_ch_valid & (cfg_ch == CH_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count      <= '0;
        r_div        <= WIDTH'(DEFAULT_DIV);
        r_sh_div     <= WIDTH'(DEFAULT_DIV);
        r_oneshot    <= 1'b0;
        r_sh_oneshot <= 1'b0;
        r_pending    <= 1'b0;
        r_tick       <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        if (w_commit) begin
          r_div     <= r_sh_div;
          r_oneshot <= r_sh_oneshot;
          r_pending <= 1'b0;
        end
        // A same-edge load lands after the commit, so the new data stays pending.
        if (w_load) begin
          r_sh_div     <= w_cfg_div;
          r_sh_oneshot <= cfg_oneshot;
          r_pending    <= 1'b1;
        end

        if (sync) begin
          r_count <= '0;
          r_tick  <= 1'b0;
          r_done  <= 1'b0;
        end else if (w_commit) begin
          // A rollover commit still emits the tick that closes the old period.
          r_count <= '0;
          r_tick  <= w_roll;
          r_done  <= 1'b0;
        end else if (w_active) begin
          if (w_roll) begin
            r_count <= '0;
            r_tick  <= 1'b1;
            r_done  <= r_oneshot;
          end else begin
            r_count <= r_count + WIDTH'(1);
            r_tick  <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
          if (!ch_en[i]) begin
            r_done <= 1'b0;
          end
        end
      end
    end

    assign tick[i]      = r_tick;
    assign done[i]      = r_done;
    assign w_pending[i] = r_pending;
  end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Directed bench for multi_tick_generator: a 4-channel instance for the main behaviour and a
// 3-channel instance so that an out-of-range channel index is representable.
module tb_multi_tick_generator;

  logic        clk = 1'b0;
  logic        rst_n, en, sync, cfg_valid, cfg_oneshot, cfg_ready, cfg_err;
  logic [3:0]  ch_en, tick, done;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;

  logic [2:0]  e_ch_en, e_tick, e_done;
  logic [1:0]  e_cfg_ch;
  logic [7:0]  e_cfg_div;
  logic        e_cfg_valid, e_cfg_ready, e_cfg_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int tcnt[4], tfirst[4], tsecond[4], tlast[4];
  int ecnt, efirst, esecond;

  always #5 clk = ~clk;

  multi_tick_generator #(.N_CH(4), .WIDTH(32), .DEFAULT_DIV(1000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_oneshot(cfg_oneshot), .cfg_err(cfg_err), .tick(tick), .done(done)
  );

  multi_tick_generator #(.N_CH(3), .WIDTH(8), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_en(e_ch_en), .sync(sync),
    .cfg_valid(e_cfg_valid), .cfg_ready(e_cfg_ready), .cfg_ch(e_cfg_ch), .cfg_div(e_cfg_div),
    .cfg_oneshot(cfg_oneshot), .cfg_err(e_cfg_err), .tick(e_tick), .done(e_done)
  );

  task automatic clear_stats();
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      tcnt[i] = 0; tfirst[i] = -1; tsecond[i] = -1; tlast[i] = -1;
    end
    ecnt = 0; efirst = -1; esecond = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (tick[i] === 1'b1) begin
        tcnt[i]++;
        if (tfirst[i] < 0) tfirst[i] = cyc - base;
        else if (tsecond[i] < 0) tsecond[i] = cyc - base;
        tlast[i] = cyc - base;
      end
    end
    if (e_tick[0] === 1'b1) begin
      ecnt++;
      if (efirst < 0) efirst = cyc - base;
      else if (esecond < 0) esecond = cyc - base;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; ch_en = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
    e_ch_en = '0; e_cfg_valid = 1'b0; e_cfg_ch = '0; e_cfg_div = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tick !== 4'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0000", tick); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_default_period();
    en = 1'b1; ch_en = 4'b0001; e_ch_en = 3'b001;
    clear_stats();
    run(2000);
    checks++; if (tcnt[0] !== 2) begin failures++; $display("FAIL default_count got=%0d exp=2", tcnt[0]); end
    checks++; if (tfirst[0] !== 1000) begin failures++; $display("FAIL default_first got=%0d exp=1000", tfirst[0]); end
    checks++; if (tsecond[0] !== 2000) begin failures++; $display("FAIL default_second got=%0d exp=2000", tsecond[0]); end
    checks++; if (tcnt[1] + tcnt[2] + tcnt[3] !== 0) begin
      failures++; $display("FAIL default_other_ticks got=%0d exp=0", tcnt[1] + tcnt[2] + tcnt[3]);
    end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL default_ready got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_midperiod_cfg();
    ch_en = 4'b0011;
    clear_stats();
    run(300);
    cfg_ch = 2'd1; cfg_div = 32'd10; cfg_oneshot = 1'b0; cfg_valid = 1'b1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_pre got=%b exp=1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_pending got=%b exp=0", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL mid_cfg_err got=%b exp=0", cfg_err); end
    run(799);
    checks++; if (tfirst[1] !== 1000) begin failures++; $display("FAIL mid_first got=%0d exp=1000", tfirst[1]); end
    checks++; if (tsecond[1] !== 1010) begin failures++; $display("FAIL mid_second got=%0d exp=1010", tsecond[1]); end
    checks++; if (tcnt[1] !== 11) begin failures++; $display("FAIL mid_count got=%0d exp=11", tcnt[1]); end
    checks++; if (tlast[1] !== 1100) begin failures++; $display("FAIL mid_last got=%0d exp=1100", tlast[1]); end
    checks++; if (tcnt[0] !== 1) begin failures++; $display("FAIL mid_ch0_count got=%0d exp=1", tcnt[0]); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_post got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_oneshot();
    cfg_ch = 2'd2; cfg_div = 32'd5; cfg_oneshot = 1'b1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL os_idle_commit got=%b exp=1", cfg_ready); end
    ch_en = 4'b0111;
    clear_stats();
    run(30);
    checks++; if (tcnt[2] !== 1) begin failures++; $display("FAIL os_count got=%0d exp=1", tcnt[2]); end
    checks++; if (tfirst[2] !== 5) begin failures++; $display("FAIL os_first got=%0d exp=5", tfirst[2]); end
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL os_done got=%b exp=0100", done); end
    ch_en = 4'b0011;
    step();
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL os_done_clear got=%b exp=0000", done); end
    ch_en = 4'b0111;
    clear_stats();
    run(30);
    checks++; if (tcnt[2] !== 1) begin failures++; $display("FAIL os_refire_count got=%0d exp=1", tcnt[2]); end
    checks++; if (tfirst[2] !== 5) begin failures++; $display("FAIL os_refire_first got=%0d exp=5", tfirst[2]); end
  endtask

  task automatic test_back_to_back();
    int lowcnt;
    sync = 1'b1;
    step();
    sync = 1'b0;
    cfg_ch = 2'd1; cfg_div = 32'd0; cfg_oneshot = 1'b0; cfg_valid = 1'b1;
    step();
    lowcnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (cfg_ready === 1'b0) lowcnt++;
      step();
    end
    checks++; if (lowcnt !== 9) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=9", lowcnt); end
    checks++; if (tick[1] !== 1'b1) begin failures++; $display("FAIL b2b_roll_tick got=%b exp=1", tick[1]); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", cfg_ready); end
    cfg_valid = 1'b0;
    clear_stats();
    run(20);
    checks++; if (tcnt[1] !== 20) begin failures++; $display("FAIL b2b_div0 got=%0d exp=20", tcnt[1]); end
  endtask

  task automatic test_sync();
    cfg_ch = 2'd1; cfg_div = 32'd500; cfg_oneshot = 1'b0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    run(600);
    cfg_div = 32'd7; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    run(99);
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sync_pending got=%b exp=0", cfg_ready); end
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (tick !== 4'b0) begin failures++; $display("FAIL sync_tick got=%b exp=0000", tick); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL sync_commit got=%b exp=1", cfg_ready); end
    clear_stats();
    run(1000);
    checks++; if (tcnt[0] !== 1) begin failures++; $display("FAIL sync_ch0_count got=%0d exp=1", tcnt[0]); end
    checks++; if (tfirst[0] !== 1000) begin failures++; $display("FAIL sync_ch0_first got=%0d exp=1000", tfirst[0]); end
    checks++; if (tfirst[1] !== 7) begin failures++; $display("FAIL sync_ch1_first got=%0d exp=7", tfirst[1]); end
    checks++; if (tcnt[1] !== 142) begin failures++; $display("FAIL sync_ch1_count got=%0d exp=142", tcnt[1]); end
    checks++; if (tcnt[2] !== 1) begin failures++; $display("FAIL sync_ch2_count got=%0d exp=1", tcnt[2]); end
  endtask

  task automatic test_err_and_reset();
    bit seen;
    e_cfg_ch = 2'd3; e_cfg_div = 8'd9; e_cfg_valid = 1'b1;
    checks++; if (e_cfg_ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%b exp=1", e_cfg_ready); end
    step();
    e_cfg_valid = 1'b0;
    checks++; if (e_cfg_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", e_cfg_err); end
    clear_stats();
    step();
    checks++; if (e_cfg_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", e_cfg_err); end
    run(7);
    checks++; if (ecnt !== 2) begin failures++; $display("FAIL err_e_count got=%0d exp=2", ecnt); end
    checks++; if (esecond - efirst !== 4) begin
      failures++; $display("FAIL err_e_period got=%0d exp=4", esecond - efirst);
    end

    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (tick[1] === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rst_wait_tick got=%b exp=1", seen); end
    rst_n = 1'b0;
    #1;
    checks++; if (tick !== 4'b0) begin failures++; $display("FAIL rst_mid_tick got=%b exp=0000", tick); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0000", done); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%b exp=0", cfg_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    run(1000);
    checks++; if (tfirst[0] !== 1000) begin failures++; $display("FAIL rst_ch0_first got=%0d exp=1000", tfirst[0]); end
    checks++; if (tcnt[1] !== 1) begin failures++; $display("FAIL rst_ch1_count got=%0d exp=1", tcnt[1]); end
    checks++; if (efirst !== 4) begin failures++; $display("FAIL rst_e_first got=%0d exp=4", efirst); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_midperiod_cfg();
    test_oneshot();
    test_back_to_back();
    test_sync();
    test_err_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
